// File: rtl/pong_pkg.sv
// Shared types and constants for the pong sound path: arbiter states and
// the sound-table indices used by the game-event requesters.
package pong_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OFFER   = 2'd1,
        ARB_PLAYING = 2'd2,
        ARB_GAP     = 2'd3
    } arb_state_t;

    localparam int unsigned SOUND_W = 6;

    localparam logic [SOUND_W-1:0] SND_SILENCE  = 6'd0;
    localparam logic [SOUND_W-1:0] SND_WALL     = 6'd1;
    localparam logic [SOUND_W-1:0] SND_PADDLE   = 6'd9;
    localparam logic [SOUND_W-1:0] SND_SCORE    = 6'd17;
    localparam logic [SOUND_W-1:0] SND_GAMEOVER = 6'd33;

endpackage

// File: rtl/sound_arbiter_prio_pick.sv
// Fixed-priority encoder: lowest set bit of vec wins; idx is 0 when vec is empty.
module prio_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] vec,
    output logic            any_valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        any_valid = |vec;
        idx       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Shares one tone player between game-event requesters: pending store,
// fixed-priority grant, handshake, completion/timeout/preempt wait, and gap.
module sound_arbiter
    import pong_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned SOUND_W = pong_pkg::SOUND_W,
    parameter logic [23:0] TIMEOUT = 24'd8_000_000,
    parameter logic [15:0] GAP     = 16'd20_000,
    parameter bit          PREEMPT = 1'b1,
    localparam int unsigned OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SOUND_W-1:0] req_idx,
    output logic [SOUND_W-1:0]      sound_sel,
    output logic                    play_valid,
    input  logic                    play_ready,
    input  logic                    player_done,
    output logic                    abort,
    output logic [NREQ-1:0]         grant,
    output logic [OW-1:0]           owner,
    output logic                    dropped,
    output logic                    timeout
);

    arb_state_t                     state_q, state_d;
    logic [NREQ-1:0]                pend_q, pend_d;
    logic [NREQ-1:0][SOUND_W-1:0]   idx_q, idx_d;
    logic [OW-1:0]                  owner_q, owner_d;
    logic [SOUND_W-1:0]             sel_q, sel_d;
    logic [NREQ-1:0]                grant_q, grant_d;
    logic                           abort_q, abort_d;
    logic                           dropped_q, dropped_d;
    logic                           timeout_q, timeout_d;
    logic [23:0]                    tcnt_q, tcnt_d;
    logic [15:0]                    gcnt_q, gcnt_d;

    logic                           pend_any;
    logic [OW-1:0]                  pend_top;
    logic                           accept;

    // The same encoder picks the next winner and, while playing, tells us
    // whether a more urgent request is waiting.
    prio_pick #(.NREQ(NREQ), .IW(OW)) u_pick (
        .vec       (pend_q),
        .any_valid (pend_any),
        .idx       (pend_top)
    );

    assign accept = (state_q == ARB_OFFER) && play_ready;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        idx_d     = idx_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        grant_d   = '0;
        abort_d   = 1'b0;
        dropped_d = 1'b0;
        timeout_d = 1'b0;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;

        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (pend_q[i] && !(accept && (owner_q == OW'(i)))) dropped_d = 1'b1;
                pend_d[i] = 1'b1;
                idx_d[i]  = req_idx[i*SOUND_W +: SOUND_W];
            end
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (pend_any) begin
                    owner_d = pend_top;
                    sel_d   = idx_q[pend_top];
                    state_d = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (play_ready) begin
                    // A fresh request from the owner in the accept cycle stays pending.
                    if (!req[owner_q]) pend_d[owner_q] = 1'b0;
                    grant_d[owner_q] = 1'b1;
                    tcnt_d           = '0;
                    state_d          = ARB_PLAYING;
                end
            end
            ARB_PLAYING: begin
                if (player_done) begin
                    gcnt_d  = '0;
                    state_d = ARB_GAP;
                end else if (tcnt_q == TIMEOUT - 24'd1) begin
                    timeout_d = 1'b1;
                    gcnt_d    = '0;
                    state_d   = ARB_GAP;
                end else if (PREEMPT && pend_any && (pend_top < owner_q)) begin
                    abort_d = 1'b1;
                    gcnt_d  = '0;
                    state_d = ARB_GAP;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 24'd1;
                end
            end
            ARB_GAP: begin
                if (gcnt_q >= GAP) begin
                    state_d = ARB_IDLE;
                end else if (gcnt_q != '1) begin
                    gcnt_d = gcnt_q + 16'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ARB_IDLE;
            pend_q    <= '0;
            idx_q     <= '0;
            owner_q   <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            abort_q   <= 1'b0;
            dropped_q <= 1'b0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            abort_q   <= abort_d;
            dropped_q <= dropped_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

    // Decoded straight from the state register so reset drops it at once.
    assign play_valid = (state_q == ARB_OFFER);
    assign sound_sel  = sel_q;
    assign owner      = owner_q;
    assign grant      = grant_q;
    assign abort      = abort_q;
    assign dropped    = dropped_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: one instance with preemption, one without,
// both with a short timeout and gap so every phase is reachable quickly.
module tb_sound_arbiter;
    import pong_pkg::*;

    localparam int NREQ = 4;
    localparam int SW   = 6;
    localparam int GAPC = 4;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*SW-1:0] req_idx = '0;
    logic              play_ready = 1'b0;
    logic              player_done = 1'b0;

    logic [SW-1:0]     sound_sel, sound_sel_np;
    logic              play_valid, play_valid_np;
    logic              abort, abort_np;
    logic [NREQ-1:0]   grant, grant_np;
    logic [1:0]        owner, owner_np;
    logic              dropped, dropped_np;
    logic              timeout, timeout_np;

    int n_checks = 0;
    int n_errors = 0;

    sound_arbiter #(.NREQ(NREQ), .SOUND_W(SW), .TIMEOUT(24'd100), .GAP(16'(GAPC)), .PREEMPT(1'b1)) u_dut (
        .clk(clk), .reset_b(reset_b), .req(req), .req_idx(req_idx),
        .sound_sel(sound_sel), .play_valid(play_valid), .play_ready(play_ready),
        .player_done(player_done), .abort(abort), .grant(grant), .owner(owner),
        .dropped(dropped), .timeout(timeout)
    );

    sound_arbiter #(.NREQ(NREQ), .SOUND_W(SW), .TIMEOUT(24'd100), .GAP(16'(GAPC)), .PREEMPT(1'b0)) u_dut_np (
        .clk(clk), .reset_b(reset_b), .req(req), .req_idx(req_idx),
        .sound_sel(sound_sel_np), .play_valid(play_valid_np), .play_ready(play_ready),
        .player_done(player_done), .abort(abort_np), .grant(grant_np), .owner(owner_np),
        .dropped(dropped_np), .timeout(timeout_np)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic send(input int i, input logic [SW-1:0] idx);
        req = '0;
        req[i] = 1'b1;
        req_idx[i*SW +: SW] = idx;
        tick();
        req = '0;
    endtask

    task automatic pulse_done();
        player_done = 1'b1;
        tick();
        player_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_b = 1'b0;
        req = '0;
        play_ready = 1'b0;
        player_done = 1'b0;
        ticks(2);
        check({tag, "_rst_valid"}, 32'(play_valid), 32'd0);
        check({tag, "_rst_sel"}, 32'(sound_sel), 32'(SND_SILENCE));
        check({tag, "_rst_grant"}, 32'(grant), 32'd0);
        check({tag, "_rst_owner"}, 32'(owner), 32'd0);
        check({tag, "_rst_pulses"}, 32'({abort, dropped, timeout}), 32'd0);
        reset_b = 1'b1;
        tick();
    endtask

    initial begin
        // Single request
        do_reset("single");
        play_ready = 1'b1;
        send(2, SND_SCORE);
        check("single_not_yet", 32'(play_valid), 32'd0);
        tick();
        check("single_valid", 32'(play_valid), 32'd1);
        check("single_sel", 32'(sound_sel), 32'(SND_SCORE));
        check("single_owner", 32'(owner), 32'd2);
        tick();
        check("single_grant", 32'(grant), 32'b0100);
        check("single_playing", 32'(play_valid), 32'd0);
        tick();
        check("single_grant_once", 32'(grant), 32'd0);
        pulse_done();
        ticks(8);
        check("single_idle", 32'(play_valid), 32'd0);

        // Priority ordering and gap length
        do_reset("prio");
        play_ready = 1'b1;
        req = 4'b1010;
        req_idx[3*SW +: SW] = SND_GAMEOVER;
        req_idx[1*SW +: SW] = SND_PADDLE;
        tick();
        req = '0;
        tick();
        check("prio_owner1", 32'(owner), 32'd1);
        check("prio_sel1", 32'(sound_sel), 32'(SND_PADDLE));
        tick();
        check("prio_grant1", 32'(grant), 32'b0010);
        pulse_done();
        ticks(GAPC + 1);
        check("prio_gap_len", 32'(play_valid), 32'd0);
        tick();
        check("prio_valid3", 32'(play_valid), 32'd1);
        check("prio_owner3", 32'(owner), 32'd3);
        check("prio_sel3", 32'(sound_sel), 32'(SND_GAMEOVER));
        tick();
        check("prio_grant3", 32'(grant), 32'b1000);
        pulse_done();
        ticks(12);
        check("prio_empty", 32'(play_valid), 32'd0);

        // Overwrite while the arbiter sits in the gap
        do_reset("ovw");
        play_ready = 1'b1;
        send(2, SND_SCORE);
        ticks(2);
        pulse_done();
        send(0, SND_WALL);
        check("ovw_first_ok", 32'(dropped), 32'd0);
        send(0, SND_PADDLE);
        check("ovw_dropped", 32'(dropped), 32'd1);
        tick();
        check("ovw_dropped_once", 32'(dropped), 32'd0);
        ticks(2);
        check("ovw_wait", 32'(play_valid), 32'd0);
        tick();
        check("ovw_valid", 32'(play_valid), 32'd1);
        check("ovw_sel", 32'(sound_sel), 32'(SND_PADDLE));
        check("ovw_owner", 32'(owner), 32'd0);

        // Preemption (with and without)
        do_reset("pre");
        play_ready = 1'b1;
        send(3, SND_GAMEOVER);
        ticks(2);
        check("pre_grant3", 32'(grant), 32'b1000);
        send(0, SND_WALL);
        check("pre_no_abort_yet", 32'(abort), 32'd0);
        tick();
        check("pre_abort", 32'(abort), 32'd1);
        check("np_abort", 32'(abort_np), 32'd0);
        tick();
        check("pre_abort_once", 32'(abort), 32'd0);
        ticks(4);
        check("pre_gap", 32'(play_valid), 32'd0);
        tick();
        check("pre_valid0", 32'(play_valid), 32'd1);
        check("pre_owner0", 32'(owner), 32'd0);
        check("pre_sel0", 32'(sound_sel), 32'(SND_WALL));
        check("np_still_playing", 32'(play_valid_np), 32'd0);
        pulse_done();
        check("pre_grant0", 32'(grant), 32'b0001);
        check("np_no_abort", 32'(abort_np), 32'd0);
        ticks(GAPC + 1);
        check("np_gap", 32'(play_valid_np), 32'd0);
        tick();
        check("np_valid0", 32'(play_valid_np), 32'd1);
        check("np_owner0", 32'(owner_np), 32'd0);
        check("np_sel0", 32'(sound_sel_np), 32'(SND_WALL));

        // Timeout after 100 playing cycles
        do_reset("tmo");
        play_ready = 1'b1;
        send(2, SND_SCORE);
        ticks(2);
        check("tmo_grant", 32'(grant), 32'b0100);
        ticks(99);
        check("tmo_early", 32'(timeout), 32'd0);
        tick();
        check("tmo_pulse", 32'(timeout), 32'd1);
        tick();
        check("tmo_pulse_once", 32'(timeout), 32'd0);

        // player_done on the expiry cycle wins over timeout
        do_reset("tdc");
        play_ready = 1'b1;
        send(2, SND_SCORE);
        ticks(2);
        ticks(99);
        pulse_done();
        check("tdc_no_timeout", 32'(timeout), 32'd0);
        check("tdc_no_abort", 32'(abort), 32'd0);
        tick();
        check("tdc_still_none", 32'(timeout), 32'd0);

        // Reset while offering with play_ready low
        do_reset("mid");
        play_ready = 1'b0;
        send(1, SND_PADDLE);
        tick();
        check("mid_valid", 32'(play_valid), 32'd1);
        #2;
        reset_b = 1'b0;
        #1;
        check("mid_rst_valid", 32'(play_valid), 32'd0);
        check("mid_rst_sel", 32'(sound_sel), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_abort", 32'(abort), 32'd0);
        reset_b = 1'b1;
        play_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("mid_no_grant", 32'({grant, play_valid}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

- Shares the single tone player between several game-event requesters (wall bounce, paddle hit, score, game over).
- Sits between the decoded PIC event strobes and the audio player, and drives the player's sound index.
- Latches each requester's pending request and grants the player by fixed priority, with optional preemption.
- Sequences each effect through a handshake, a completion/timeout wait and an inter-sound gap.

## Interface
Parameters:
- NREQ, 4, number of requesters; index 0 has the highest priority.
- SOUND_W, 6, sound-table index width (64-entry table).
- TIMEOUT, 24'd8_000_000, max cycles in PLAYING before forced release.
- GAP, 16'd20_000, silent cycles between effects; 0 allowed.
- PREEMPT, 1, 1 lets a higher-priority pending request abort the current effect.

Ports:
- clk, input, 1, system clock.
- reset_b, input, 1, asynchronous active-low reset.
- req, input, NREQ, single-cycle request strobes, one per requester.
- req_idx, input, NREQ*SOUND_W, sound index per requester; slice i is sampled with req[i].
- sound_sel, output, SOUND_W, index presented to the player.
- play_valid, output, 1, offer to the player.
- play_ready, input, 1, player accepts the offer.
- player_done, input, 1, one-cycle pulse at the end of the effect.
- abort, output, 1, one-cycle pulse telling the player to stop immediately.
- grant, output, NREQ, one-hot, one-cycle pulse on acceptance.
- owner, output, $clog2(NREQ), requester currently offered or playing.
- dropped, output, 1, one-cycle pulse when a request overwrites a still-pending one.
- timeout, output, 1, one-cycle pulse on forced release.

## Operation
- **Pending store.** Per requester i there is a pend[i] bit and a stored index.
  - req[i] sets pend[i] and captures req_idx slice i.
  - If pend[i] was already set and is not being granted in that cycle, dropped pulses and the newer index wins.
- **Arbitration.** Fixed priority: lowest set index among pend wins.
- **State machine** (states IDLE, OFFER, PLAYING, GAP):
  - IDLE: if any pend, register the winner into owner and its index into sound_sel, then go to OFFER. The winner is frozen for the rest of the OFFER.
  - OFFER: play_valid=1. When play_valid&play_ready: clear pend[owner], pulse grant[owner], clear the timeout counter, go to PLAYING.
  - OFFER, same-cycle req[owner]: pend stays set with the new index and dropped is not asserted.
  - PLAYING, on player_done: go to GAP.
  - PLAYING, when the counter reaches TIMEOUT-1: pulse timeout, go to GAP.
  - PLAYING, if PREEMPT and a pend index is lower than owner: pulse abort, go to GAP.
  - PLAYING, simultaneous events: player_done takes precedence over timeout and over preempt; on that cycle neither timeout nor abort pulses.
  - GAP: count GAP cycles, then go to IDLE. GAP=0 means one cycle in GAP, then IDLE.
- **Ignored inputs.** player_done outside PLAYING and play_ready outside OFFER are ignored.
- **Counters.**
  - Timeout counter is 24-bit; gap counter is 16-bit; both saturate and never wrap.
  - Both counters reset to 0 on every entry into their state.

## Timing
- **Reset values.** While reset_b is low, all outputs are 0: sound_sel=0 (silence), play_valid=0, grant=0, owner=0, abort=0, dropped=0, timeout=0. State is IDLE and all pend bits are cleared.
- **Reset mid-operation.** Asserting reset_b during OFFER or PLAYING drops play_valid combinationally-asynchronously; no abort pulse is issued.
- **Latency.** req[i] sampled at edge k (IDLE, no higher-priority pend) → owner/sound_sel/play_valid valid after edge k+1.
- **Handshake.**
  - play_valid holds, with sound_sel stable, until accepted.
  - grant pulses in the cycle after edge k+1 when play_ready is high in that cycle.
- **Release.** player_done at edge m → GAP from m+1; the next play_valid comes no earlier than edge m+GAP+2.
- **Registered outputs.** All outputs are registered except play_valid, which is decoded from the state register (glitch-free).

## Structure
- **Package pong_pkg:**
  - arb_state_t enum {IDLE, OFFER, PLAYING, GAP}.
  - SOUND_W.
  - Sound index constants: SND_SILENCE=0, SND_WALL=1, SND_PADDLE=9, SND_SCORE=17, SND_GAMEOVER=33.
- **Sub-module prio_pick.** Parameterized fixed-priority encoder: input NREQ vector; outputs any_valid and a binary index. It is also used for the preemption compare.

## Test plan
- **Single request.** Reset, then req[2] with idx 17, play_ready tied high → play_valid after 2 edges, sound_sel=17, grant=4'b0100, owner=2; player_done → GAP cycles, then IDLE with play_valid low.
- **Priority ordering.** req[3] and req[1] in the same cycle → req[1] is served first; after its done and the GAP, req[3] is served; pend ends at 0.
- **Overwrite.** req[0] idx 1, then req[0] idx 9 before grant → dropped pulses once; the played sound_sel=9.
- **Preemption.** PREEMPT=1, requester 3 playing, req[0] arrives → abort pulses one cycle, then GAP, then requester 0 is offered. With PREEMPT=0 → no abort; requester 0 waits for done.
- **Timeout and conflict.** TIMEOUT=100 with no player_done → timeout pulses 100 cycles after grant. Separately, player_done on the same cycle as the timeout expiry → no timeout pulse.
- **Reset mid-handshake.** reset_b low during OFFER with play_ready low → all outputs 0 immediately, pend cleared; no grant after release.
